// File: rtl/fwd_scoreboard_unit.sv
// Operand-forwarding and load-use hazard controller for the pipelined MIPS32 core.
// Sits in ID and tracks in-flight register writers from EX onward in a shift-register
// scoreboard. For each source operand it picks the youngest matching producer and raises a
// stall when that producer is a load whose result is not yet forwardable. The forward
// selects are registered so they line up with the consumer once it reaches EX.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_n          asynchronous active-low reset
//   id_valid_i     a valid instruction is in ID
//   id_src_i       packed source register addresses, src s = [s*REG_AW +: REG_AW]
//   id_src_used_i  per-source read enable
//   id_rd_i        destination register of the ID instruction
//   id_regwrite_i  ID instruction writes id_rd_i
//   id_is_load_i   ID instruction is a load
//   pipe_hold_i    global freeze
//   flush_i        kill the ID instruction and the EX-stage entry
//   stall_o        hold PC and IF/ID, bubble into EX (combinational)
//   fwd_sel_o      registered per-source select: 0 = regfile, k = forward index k
//   stall_cnt_o    saturating count of stall cycles
module fwd_scoreboard_unit #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned FWD_DEPTH = 3,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned SEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0]  id_src_i,
  input  logic [NUM_SRC-1:0]         id_src_used_i,
  input  logic [REG_AW-1:0]          id_rd_i,
  input  logic                       id_regwrite_i,
  input  logic                       id_is_load_i,
  input  logic                       pipe_hold_i,
  input  logic                       flush_i,
  output logic                       stall_o,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  if (!((FWD_DEPTH + 1 <= (1 << SEL_W)) && (LOAD_LAT < FWD_DEPTH))) begin : g_param_check
    $error("fwd_scoreboard_unit: FWD_DEPTH/LOAD_LAT out of range");
  end

  // Entry 0 is the instruction currently in EX; higher indices are older.
  logic [FWD_DEPTH-1:0] e_v_q, e_v_d;
  logic [FWD_DEPTH-1:0] e_ld_q, e_ld_d;
  logic [REG_AW-1:0]    e_rd_q [FWD_DEPTH];
  logic [REG_AW-1:0]    e_rd_d [FWD_DEPTH];

  logic [NUM_SRC*SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [NUM_SRC*SEL_W-1:0] cand_sel;
  logic [NUM_SRC-1:0]       hit;
  logic [NUM_SRC-1:0]       need_stall;
  logic                     issue;

  // Youngest-match search. Once a source has a winner, older entries are ignored, so an
  // older forwardable copy can never mask a younger load hazard.
  always_comb begin
    cand_sel   = '0;
    hit        = '0;
    need_stall = '0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      for (int k = 0; k < int'(FWD_DEPTH); k++) begin
        if (!hit[s] && e_v_q[k] && (e_rd_q[k] == id_src_i[s*REG_AW +: REG_AW])) begin
          hit[s] = 1'b1;
          if (id_src_used_i[s]) begin
            cand_sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
            need_stall[s]              = e_ld_q[k] && ((k + 1) <= int'(LOAD_LAT));
          end
        end
      end
    end
  end

  assign stall_o = id_valid_i && !flush_i && (|need_stall);
  assign issue   = id_valid_i && !stall_o && !flush_i;

  always_comb begin
    e_v_d  = e_v_q;
    e_ld_d = e_ld_q;
    e_rd_d = e_rd_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    if (!pipe_hold_i) begin
      // A flushed EX entry still shifts, but arrives in entry 1 as invalid.
      for (int k = int'(FWD_DEPTH) - 1; k >= 1; k--) begin
        e_v_d[k]  = e_v_q[k-1] && !((k == 1) && flush_i);
        e_ld_d[k] = e_ld_q[k-1];
        e_rd_d[k] = e_rd_q[k-1];
      end
      e_v_d[0]  = issue && id_regwrite_i && (id_rd_i != '0);
      e_ld_d[0] = id_is_load_i;
      e_rd_d[0] = id_rd_i;
      sel_d     = issue ? cand_sel : '0;
      if (stall_o && !(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (flush_i) begin
      // Flush under hold kills the EX entry in place without shifting.
      e_v_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      e_v_q  <= '0;
      e_ld_q <= '0;
      for (int k = 0; k < int'(FWD_DEPTH); k++) begin
        e_rd_q[k] <= '0;
      end
      sel_q  <= '0;
      cnt_q  <= '0;
    end else begin
      e_v_q  <= e_v_d;
      e_ld_q <= e_ld_d;
      e_rd_q <= e_rd_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fwd_sel_o   = sel_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
module tb_fwd_scoreboard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_is_load;
  logic        pipe_hold;
  logic        flush;
  logic        stall, stall_s;
  logic [3:0]  fwd_sel, fwd_sel_s;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_s;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fwd_scoreboard_unit u_dut (
    .clk_i         (clk),
    .rst_n         (rst_n),
    .id_valid_i    (id_valid),
    .id_src_i      (id_src),
    .id_src_used_i (id_src_used),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_is_load_i  (id_is_load),
    .pipe_hold_i   (pipe_hold),
    .flush_i       (flush),
    .stall_o       (stall),
    .fwd_sel_o     (fwd_sel),
    .stall_cnt_o   (stall_cnt)
  );

  // Same stimulus, narrow counter for the saturation check.
  fwd_scoreboard_unit #(.CNT_W(4)) u_sat (
    .clk_i         (clk),
    .rst_n         (rst_n),
    .id_valid_i    (id_valid),
    .id_src_i      (id_src),
    .id_src_used_i (id_src_used),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_is_load_i  (id_is_load),
    .pipe_hold_i   (pipe_hold),
    .flush_i       (flush),
    .stall_o       (stall_s),
    .fwd_sel_o     (fwd_sel_s),
    .stall_cnt_o   (stall_cnt_s)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  s0;
    logic [4:0]  s1;
    logic [1:0]  used;
    logic [4:0]  rd;
    logic        rw;
    logic        ld;
    logic        hold;
    logic        fl;
    logic        exp_stall;
    logic [1:0]  exp_sel0;
    logic [1:0]  exp_sel1;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                              input logic [1:0] used, input logic [4:0] rd, input logic rw,
                              input logic ld, input logic hold, input logic fl,
                              input logic est, input logic [1:0] es0, input logic [1:0] es1,
                              input logic [15:0] ecnt);
    vec_t r;
    r.valid = v;  r.s0 = s0;  r.s1 = s1;  r.used = used;  r.rd = rd;  r.rw = rw;
    r.ld = ld;  r.hold = hold;  r.fl = fl;  r.exp_stall = est;  r.exp_sel0 = es0;
    r.exp_sel1 = es1;  r.exp_cnt = ecnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [4:0] rd, input logic rw,
                       input logic ld, input logic hold, input logic fl);
    id_valid = v;  id_src = {s1, s0};  id_src_used = used;  id_rd = rd;
    id_regwrite = rw;  id_is_load = ld;  pipe_hold = hold;  flush = fl;
  endtask

  initial begin
    //                v  s0  s1  used   rd  rw ld hd fl  stall sel0 sel1 cnt
    tbl[0]  = mk(1, 0,  0,  2'b00, 3,  1, 0, 0, 0, 0, 0, 0, 0);  // add r3
    tbl[1]  = mk(1, 3,  0,  2'b01, 7,  1, 0, 0, 0, 0, 1, 0, 0);  // sub uses r3 -> 1
    tbl[2]  = mk(1, 0,  0,  2'b00, 8,  1, 0, 0, 0, 0, 0, 0, 0);  // independent
    tbl[3]  = mk(1, 7,  0,  2'b01, 0,  0, 0, 0, 0, 0, 2, 0, 0);  // r7 one apart -> 2
    tbl[4]  = mk(1, 0,  0,  2'b00, 5,  1, 1, 0, 0, 0, 0, 0, 0);  // lw r5
    tbl[5]  = mk(1, 5,  0,  2'b01, 9,  1, 0, 0, 0, 1, 0, 0, 1);  // load-use stall
    tbl[6]  = mk(1, 5,  0,  2'b01, 9,  1, 0, 0, 0, 0, 2, 0, 1);  // issues with 2
    tbl[7]  = mk(1, 0,  0,  2'b00, 4,  1, 0, 0, 0, 0, 0, 0, 1);  // add r4
    tbl[8]  = mk(1, 0,  0,  2'b00, 4,  1, 0, 0, 0, 0, 0, 0, 1);  // or r4
    tbl[9]  = mk(1, 4,  4,  2'b11, 10, 1, 0, 0, 0, 0, 1, 1, 1);  // youngest on both
    tbl[10] = mk(1, 0,  0,  2'b00, 0,  1, 0, 0, 0, 0, 0, 0, 1);  // addi r0
    tbl[11] = mk(1, 0,  0,  2'b11, 0,  0, 0, 0, 0, 0, 0, 0, 1);  // read r0
    tbl[12] = mk(1, 0,  0,  2'b00, 11, 1, 1, 0, 0, 0, 0, 0, 1);  // lw r11
    tbl[13] = mk(1, 11, 11, 2'b00, 0,  0, 0, 0, 0, 0, 0, 0, 1);  // unused match
    tbl[14] = mk(1, 0,  0,  2'b00, 6,  1, 1, 0, 0, 0, 0, 0, 1);  // lw r6
    tbl[15] = mk(1, 6,  0,  2'b01, 12, 1, 0, 0, 1, 0, 0, 0, 1);  // flush
    tbl[16] = mk(1, 6,  0,  2'b01, 13, 1, 0, 0, 0, 0, 0, 0, 1);  // r6 killed -> 0
    tbl[17] = mk(1, 13, 0,  2'b01, 14, 1, 1, 0, 0, 0, 1, 0, 1);  // lw r14 uses r13
    tbl[18] = mk(1, 14, 0,  2'b01, 15, 1, 0, 1, 0, 1, 1, 0, 1);  // held load-use
    tbl[19] = mk(1, 14, 0,  2'b01, 15, 1, 0, 1, 0, 1, 1, 0, 1);
    tbl[20] = mk(1, 14, 0,  2'b01, 15, 1, 0, 1, 0, 1, 1, 0, 1);
    tbl[21] = mk(1, 14, 0,  2'b01, 15, 1, 0, 0, 0, 1, 0, 0, 2);  // hold released
    tbl[22] = mk(1, 14, 0,  2'b01, 15, 1, 0, 0, 0, 0, 2, 0, 2);

    rst_n = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset stall", {31'd0, stall}, 0);
    check("reset fwd_sel", {28'd0, fwd_sel}, 0);
    check("reset stall_cnt", {16'd0, stall_cnt}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].valid, tbl[i].s0, tbl[i].s1, tbl[i].used, tbl[i].rd, tbl[i].rw,
            tbl[i].ld, tbl[i].hold, tbl[i].fl);
      #2;
      check($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, tbl[i].exp_stall});
      @(posedge clk);
      #1;
      check($sformatf("row%0d sel0", i), {30'd0, fwd_sel[1:0]}, {30'd0, tbl[i].exp_sel0});
      check($sformatf("row%0d sel1", i), {30'd0, fwd_sel[3:2]}, {30'd0, tbl[i].exp_sel1});
      check($sformatf("row%0d cnt", i), {16'd0, stall_cnt}, {16'd0, tbl[i].exp_cnt});
    end

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge clk);
    drive(1, 0, 0, 2'b00, 15, 1, 1, 0, 0);
    @(negedge clk);
    drive(1, 15, 0, 2'b01, 16, 1, 0, 0, 0);
    #2;
    check("pre-reset stall", {31'd0, stall}, 1);
    check("pre-reset cnt", {16'd0, stall_cnt}, 2);
    rst_n = 1'b0;
    #1;
    check("async reset stall", {31'd0, stall}, 0);
    check("async reset fwd_sel", {28'd0, fwd_sel}, 0);
    check("async reset cnt", {16'd0, stall_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Repeated load-use pairs: one stall each; narrow counter must stop at 15.
    for (int it = 0; it < 20; it++) begin
      @(negedge clk);
      drive(1, 0, 0, 2'b00, 5, 1, 1, 0, 0);
      @(negedge clk);
      drive(1, 5, 0, 2'b01, 9, 1, 0, 0, 0);
      #2;
      check($sformatf("sat it%0d stall", it), {31'd0, stall}, 1);
      @(negedge clk);
      drive(1, 5, 0, 2'b01, 9, 1, 0, 0, 0);
      if (it == 14) check("sat reach 15", {28'd0, stall_cnt_s}, 15);
    end
    @(negedge clk);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("sat held at 15", {28'd0, stall_cnt_s}, 15);
    check("wide cnt 20", {16'd0, stall_cnt}, 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
